// File: rtl/pool_input_map_writer.sv
// pool_input_map_writer
// Streams one full pooling input feature map (all channels, raster order
// col -> row -> channel) into the pool input BRAM write port, then holds the
// pool engine enabled until it reports completion, blocking new samples.
//
// Ports:
//   clk, reset          single rising-edge clock, async active-low reset
//   in_valid/in_ready   producer handshake; in_data sample, in_last frame marker
//   bram_en/bram_we     registered BRAM write strobe (one per accepted sample)
//   bram_addr/bram_din  registered BRAM write address / data
//   pool_start          level enable to the pool engine while running
//   pool_done           one-cycle completion pulse from the pool engine
//   frame_err           sticky: in_last disagreed with the counted frame end
//   busy                high while flushing the last write or pooling
//
// Build option: define POOL_WRITER_RELU_EN to clamp negative samples to zero
// on their way into the BRAM.

module pool_input_map_writer #(
  parameter int unsigned input_size                  = 20,
  parameter int unsigned channel                     = 6,
  parameter int unsigned input_map_address_datawidth = 13,
  parameter int unsigned number_datawidth            = 16
) (
  input  logic                                   clk,
  input  logic                                   reset,
  input  logic                                   in_valid,
  output logic                                   in_ready,
  input  logic [number_datawidth-1:0]            in_data,
  input  logic                                   in_last,
  output logic                                   bram_en,
  output logic                                   bram_we,
  output logic [input_map_address_datawidth-1:0] bram_addr,
  output logic [number_datawidth-1:0]            bram_din,
  output logic                                   pool_start,
  input  logic                                   pool_done,
  output logic                                   frame_err,
  output logic                                   busy
);

  localparam int unsigned AW    = input_map_address_datawidth;
  localparam int unsigned DW    = number_datawidth;
  localparam int unsigned COL_W = (input_size > 1) ? $clog2(input_size) : 1;
  localparam int unsigned CH_W  = (channel > 1) ? $clog2(channel) : 1;
  localparam int unsigned PLANE = input_size * input_size;

  typedef enum logic [1:0] {LOAD, WRITE_FLUSH, RUN} state_t;

  state_t             state, state_d;
  logic [COL_W-1:0]   col, col_d, row, row_d;
  logic [CH_W-1:0]    ch, ch_d;
  logic               wr, wr_d;
  logic [AW-1:0]      addr_d;
  logic [DW-1:0]      din_d, din_val;
  logic               ready_d, start_d, busy_d, err_d;
  logic               accept, col_end, row_end, ch_end, last_pos;

  // Both strobes share one register: every write is a full-word store.
  assign bram_en = wr;
  assign bram_we = wr;

  // Sample value presented to the BRAM.
  always_comb begin
    din_val = in_data;
`ifdef POOL_WRITER_RELU_EN
    if (in_data[DW-1]) din_val = '0;
`endif
  end

  // Next-state and registered-output values.
  always_comb begin
    state_d = state;
    col_d   = col;
    row_d   = row;
    ch_d    = ch;
    wr_d    = 1'b0;
    addr_d  = bram_addr;
    din_d   = bram_din;

    accept   = (state == LOAD) && in_ready && in_valid;
    col_end  = (col == COL_W'(input_size - 1));
    row_end  = (row == COL_W'(input_size - 1));
    ch_end   = (ch == CH_W'(channel - 1));
    last_pos = col_end && row_end && ch_end;
    // Frame end is decided by the counters; in_last is only cross-checked.
    err_d    = frame_err | (accept && (in_last != last_pos));

    case (state)
      LOAD: begin
        if (accept) begin
          wr_d   = 1'b1;
          addr_d = AW'(ch) * AW'(PLANE) + AW'(row) * AW'(input_size) + AW'(col);
          din_d  = din_val;
          if (col_end) begin
            col_d = '0;
            if (row_end) begin
              row_d = '0;
              ch_d  = ch_end ? '0 : ch + CH_W'(1);
            end else begin
              row_d = row + COL_W'(1);
            end
          end else begin
            col_d = col + COL_W'(1);
          end
          if (last_pos) state_d = WRITE_FLUSH;
        end
      end
      WRITE_FLUSH: state_d = RUN;
      RUN: if (pool_done) state_d = LOAD;
      default: state_d = LOAD;
    endcase

    ready_d = (state_d == LOAD);
    busy_d  = (state_d != LOAD);
    // Enable follows RUN by one cycle but drops on the same edge as pool_done.
    start_d = (state == RUN) && !pool_done;
  end

  // State and output registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= LOAD;
      col        <= '0;
      row        <= '0;
      ch         <= '0;
      wr         <= 1'b0;
      bram_addr  <= '0;
      bram_din   <= '0;
      in_ready   <= 1'b0;
      pool_start <= 1'b0;
      busy       <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      state      <= state_d;
      col        <= col_d;
      row        <= row_d;
      ch         <= ch_d;
      wr         <= wr_d;
      bram_addr  <= addr_d;
      bram_din   <= din_d;
      in_ready   <= ready_d;
      pool_start <= start_d;
      busy       <= busy_d;
      frame_err  <= err_d;
    end
  end

endmodule

// File: tb/tb_pool_input_map_writer.sv
// Testbench for pool_input_map_writer: drives randomized frames and checks
// the BRAM write stream against an expected-write queue, plus the
// pool_start / busy / frame_err / in_ready sequencing around each frame.

module tb_pool_input_map_writer;

  localparam int FRAME = 2400;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid, in_ready, in_last;
  logic [15:0] in_data;
  logic        bram_en, bram_we;
  logic [12:0] bram_addr;
  logic [15:0] bram_din;
  logic        pool_start, pool_done, frame_err, busy;

  int vectors = 0;
  int miscompares = 0;
  logic [31:0] exp_q[$];
  logic        model_err;

  always #5 clk = ~clk;

  pool_input_map_writer dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
    .bram_en(bram_en), .bram_we(bram_we), .bram_addr(bram_addr), .bram_din(bram_din),
    .pool_start(pool_start), .pool_done(pool_done),
    .frame_err(frame_err), .busy(busy)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [15:0] model_din(input logic [15:0] d);
`ifdef POOL_WRITER_RELU_EN
    return ($signed(d) < 0) ? 16'h0000 : d;
`else
    return d;
`endif
  endfunction

  // Monitor: a write must appear exactly one edge after each accepted beat.
  initial begin
    logic [31:0] e;
    forever begin
      @(posedge clk);
      #1;
      if (reset === 1'b1 && (bram_we !== 1'b0 || exp_q.size() > 0)) begin
        if (exp_q.size() == 0) begin
          chk("spurious_write", 32'(bram_we), 32'd0);
        end else begin
          e = exp_q.pop_front();
          chk("bram_we", 32'(bram_we), 32'd1);
          chk("bram_en", 32'(bram_en), 32'd1);
          chk("bram_addr", 32'(bram_addr), 32'(e[31:16]));
          chk("bram_din", 32'(bram_din), 32'(e[15:0]));
        end
      end
    end
  end

  task automatic do_reset();
    @(negedge clk);
    #2;
    reset     = 1'b0;
    in_valid  = 1'b0;
    in_last   = 1'b0;
    pool_done = 1'b0;
    in_data   = '0;
    #1;
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    chk("rst_bram_en", 32'(bram_en), 32'd0);
    chk("rst_bram_we", 32'(bram_we), 32'd0);
    chk("rst_bram_addr", 32'(bram_addr), 32'd0);
    chk("rst_bram_din", 32'(bram_din), 32'd0);
    chk("rst_pool_start", 32'(pool_start), 32'd0);
    chk("rst_frame_err", 32'(frame_err), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    exp_q.delete();
    model_err = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("release_in_ready", 32'(in_ready), 32'd1);
  endtask

  // mode 0: always valid, 1: toggle, 2: random. stop_at >= 0 abandons the frame.
  task automatic run_frame(input int mode, input int last_pos, input int stop_at,
                           input bit data_is_addr);
    int idx = 0;
    int cyc = 0;
    bit v;
    while (idx < FRAME) begin
      @(negedge clk);
      cyc++;
      if (cyc > 20000) begin
        miscompares++;
        $display("FAIL frame_timeout: got %0d beats expected %0d", idx, FRAME);
        in_valid = 1'b0;
        return;
      end
      if (stop_at >= 0 && idx == stop_at) begin
        in_valid = 1'b0;
        return;
      end
      case (mode)
        0:       v = 1'b1;
        1:       v = (cyc % 2) == 1;
        default: v = 1'($urandom_range(0, 1));
      endcase
      in_valid  = v;
      in_data   = data_is_addr ? 16'(idx) : 16'($urandom);
      if (!data_is_addr && idx == 5) in_data = 16'hFF00;
      if (!data_is_addr && idx == 6) in_data = 16'h0100;
      in_last   = (idx == last_pos);
      pool_done = (mode == 1 && cyc == 7);
      if (v && in_ready) begin
        exp_q.push_back({16'(idx), model_din(in_data)});
        if (in_last != (idx == FRAME - 1)) model_err = 1'b1;
        idx++;
      end
    end
    // Post-frame: flush cycle, then pool_start two edges after the last accept.
    @(negedge clk);
    in_valid = 1'b0; in_last = 1'b0; pool_done = 1'b0;
    chk("flush_in_ready", 32'(in_ready), 32'd0);
    chk("flush_busy", 32'(busy), 32'd1);
    chk("flush_pool_start", 32'(pool_start), 32'd0);
    @(negedge clk);
    chk("run0_pool_start", 32'(pool_start), 32'd0);
    @(negedge clk);
    chk("run_pool_start", 32'(pool_start), 32'd1);
    chk("frame_err", 32'(frame_err), 32'(model_err));
    // Producer keeps pushing while pooling runs; nothing may be accepted.
    in_valid = 1'b1;
    in_data  = 16'h1234;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      chk("run_in_ready", 32'(in_ready), 32'd0);
      chk("run_hold_start", 32'(pool_start), 32'd1);
    end
    pool_done = 1'b1;
    @(negedge clk);
    pool_done = 1'b0;
    in_valid  = 1'b0;
    chk("done_pool_start", 32'(pool_start), 32'd0);
    chk("done_in_ready", 32'(in_ready), 32'd1);
    chk("done_busy", 32'(busy), 32'd0);
  endtask

  initial begin
    reset = 1'b0; in_valid = 1'b0; in_last = 1'b0; pool_done = 1'b0; in_data = '0;
    model_err = 1'b0;
    do_reset();
    run_frame(0, FRAME - 1, -1, 1'b1);   // full-rate frame, data = address
    run_frame(1, FRAME - 1, -1, 1'b0);   // 1/0 valid, stray pool_done in LOAD
    run_frame(2, 399, -1, 1'b0);         // early in_last -> frame_err
    run_frame(0, FRAME - 1, 1000, 1'b0); // abandoned at beat 1000
    chk("err_sticky", 32'(frame_err), 32'd1);
    do_reset();
    run_frame(2, FRAME - 1, -1, 1'b0);   // clean frame after mid-frame reset
    repeat (3) @(negedge clk);
    chk("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
